// File: rtl/visualizador_suma.sv
// visualizador_suma: captures the 9-bit adder sum on a load pulse and converts it
// to three BCD digits with a sequential double-dabble FSM. The registered result
// drives a 3-digit multiplexed 7-segment display with leading-zero blanking.
// The decimal point of the units digit shows the adder carry (sum[8]).
//
// Handshake: listo=1 only in IDLE, and a load is accepted on any rising clk edge
// where cargar=1 and listo=1. A load requested while listo=0 is dropped, not
// queued. valido is a one-cycle pulse in the cycle that bcd first holds the new
// value. Between two loads, bcd and the carry flag keep their previous values.
module visualizador_suma #(
  parameter int DIV_REFRESH = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  sum,
  input  logic        cargar,
  output logic        listo,
  output logic        valido,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [2:0]  an,
  output logic [1:0]  o_dbg_estado
);

  localparam int RW = (DIV_REFRESH > 2) ? $clog2(DIV_REFRESH) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DESPLAZAR = 2'd1,
    FIN       = 2'd2
  } estado_t;

  estado_t       r_estado;
  estado_t       w_estado_sig;

  logic [8:0]    r_desp;        // shift register holding the remaining sum bits
  logic [11:0]   r_acc;         // BCD accumulator under construction
  logic [3:0]    r_iter;        // number of shifts already done
  logic          r_carry_trab;  // carry captured with the current conversion
  logic [11:0]   r_bcd;         // last completed conversion
  logic          r_carry_flag;  // carry that belongs to r_bcd

  logic [RW-1:0] r_refresco;
  logic [1:0]    r_idx;

  logic          w_acepta;
  logic          w_ultimo;
  logic [11:0]   w_acc_aj;
  logic [11:0]   w_acc_sig;
  logic [8:0]    w_desp_sig;
  logic [3:0]    w_nibble;
  logic          w_blanco;

  // Add 3 to a nibble that is 5 or more, so the next shift carries correctly.
  function automatic logic [3:0] f_ajuste(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Active-low 7-segment code; anything outside 0..9 is shown blank.
  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign w_acepta   = (r_estado == IDLE) && cargar;
  assign w_ultimo   = (r_estado == DESPLAZAR) && (r_iter == 4'd8);
  assign w_acc_aj   = {f_ajuste(r_acc[11:8]), f_ajuste(r_acc[7:4]), f_ajuste(r_acc[3:0])};
  assign w_acc_sig  = {w_acc_aj[10:0], r_desp[8]};
  assign w_desp_sig = {r_desp[7:0], 1'b0};

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_estado <= IDLE;
    else     r_estado <= w_estado_sig;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    w_estado_sig = r_estado;
    listo        = 1'b0;
    valido       = 1'b0;
    case (r_estado)
      IDLE: begin
        listo = 1'b1;
        if (cargar) w_estado_sig = DESPLAZAR;
      end
      DESPLAZAR: begin
        if (r_iter == 4'd8) w_estado_sig = FIN;
      end
      FIN: begin
        valido       = 1'b1;
        w_estado_sig = IDLE;
      end
      default: w_estado_sig = IDLE;
    endcase
  end

  assign o_dbg_estado = r_estado;

  // Conversion datapath: load on accept, adjust-and-shift while converting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_desp       <= '0;
      r_acc        <= '0;
      r_iter       <= '0;
      r_carry_trab <= 1'b0;
    end else if (w_acepta) begin
      r_desp       <= sum;
      r_acc        <= '0;
      r_iter       <= '0;
      r_carry_trab <= sum[8];
    end else if (r_estado == DESPLAZAR) begin
      r_desp <= w_desp_sig;
      r_acc  <= w_acc_sig;
      r_iter <= r_iter + 4'd1;
    end
  end

  // Result registers change only when a conversion completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcd        <= '0;
      r_carry_flag <= 1'b0;
    end else if (w_ultimo) begin
      r_bcd        <= w_acc_sig;
      r_carry_flag <= r_carry_trab;
    end
  end

  assign bcd = r_bcd;

  // Display scan: hold each digit for DIV_REFRESH cycles, then move to the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_refresco <= '0;
      r_idx      <= '0;
    end else if (r_refresco == RW'(DIV_REFRESH - 1)) begin
      r_refresco <= '0;
      r_idx      <= (r_idx == 2'd2) ? 2'd0 : (r_idx + 2'd1);
    end else begin
      r_refresco <= r_refresco + RW'(1);
    end
  end

  // Digit selection, leading-zero blanking and decimal point.
  always_comb begin
    w_nibble = 4'd0;
    w_blanco = 1'b1;
    an       = 3'b111;
    case (r_idx)
      2'd0: begin
        an       = 3'b110;
        w_nibble = r_bcd[3:0];
        w_blanco = 1'b0;
      end
      2'd1: begin
        an       = 3'b101;
        w_nibble = r_bcd[7:4];
        w_blanco = (r_bcd[11:4] == 8'd0);
      end
      2'd2: begin
        an       = 3'b011;
        w_nibble = r_bcd[11:8];
        w_blanco = (r_bcd[11:8] == 4'd0);
      end
      default: begin
        an       = 3'b111;
        w_blanco = 1'b1;
      end
    endcase
    seg = w_blanco ? 7'h7F : f_seg(w_nibble);
    dp  = !((r_idx == 2'd0) && r_carry_flag);
  end

endmodule

// File: tb/tb_visualizador_suma.sv
// Directed bench for visualizador_suma with a short scan period.
module tb_visualizador_suma;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  sum;
  logic        cargar;
  logic        listo;
  logic        valido;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic        dp;
  logic [2:0]  an;
  logic [1:0]  o_dbg_estado;

  int n_checks = 0;
  int n_pass   = 0;

  visualizador_suma #(.DIV_REFRESH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .sum          (sum),
    .cargar       (cargar),
    .listo        (listo),
    .valido       (valido),
    .bcd          (bcd),
    .seg          (seg),
    .dp           (dp),
    .an           (an),
    .o_dbg_estado (o_dbg_estado)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One load, then watch 12 cycles: listo low time, valido timing, bcd hold.
  task automatic convert(input string tag, input logic [8:0] s, input logic [11:0] exp_bcd,
                         input logic [11:0] old_bcd, output int dp_lows);
    int lows, pulses, pk, hold_err;
    lows = 0; pulses = 0; pk = -1; hold_err = 0; dp_lows = 0;
    @(negedge clk); sum = s; cargar = 1'b1;
    @(posedge clk);
    @(negedge clk); cargar = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (!listo) lows++;
      if (valido) begin pulses++; pk = k; end
      if (k < 9 && bcd !== old_bcd) hold_err++;
      if (!dp) dp_lows++;
    end
    check({tag, "_listo_low"}, 16'(lows), 16'd10);
    check({tag, "_valido_cnt"}, 16'(pulses), 16'd1);
    check({tag, "_valido_at"}, 16'(pk), 16'd9);
    check({tag, "_hold"}, 16'(hold_err), 16'd0);
    check({tag, "_bcd"}, 16'(bcd), 16'(exp_bcd));
  endtask

  // Align on the start of a units period, then check a whole 12-cycle scan.
  task automatic scan_check(input string tag, input logic [6:0] su, input logic [6:0] st,
                            input logic [6:0] sh, input logic dpu);
    bit found;
    logic [10:0] e;
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      @(negedge clk);
      if (an == 3'b011) found = 1'b1;
    end
    if (found) begin
      found = 1'b0;
      for (int w = 0; w < 10 && !found; w++) begin
        @(negedge clk);
        if (an == 3'b110) found = 1'b1;
      end
    end
    check({tag, "_sync"}, 16'(found), 16'd1);
    if (found) begin
      for (int c = 0; c < 12; c++) begin
        if (c > 0) @(negedge clk);
        case (c / 4)
          0:       e = {3'b110, su, dpu};
          1:       e = {3'b101, st, 1'b1};
          default: e = {3'b011, sh, 1'b1};
        endcase
        check({tag, "_an_seg_dp"}, 16'({an, seg, dp}), 16'(e));
      end
    end
  endtask

  initial begin
    int dpl, pulses, hold_err, prev_k, np;
    rst = 1'b1; cargar = 1'b0; sum = '0;
    repeat (2) @(negedge clk);
    // Reset state.
    check("rst_listo", 16'(listo), 16'd1);
    check("rst_valido", 16'(valido), 16'd0);
    check("rst_bcd", 16'(bcd), 16'h000);
    check("rst_an", 16'(an), 16'(3'b110));
    check("rst_seg", 16'(seg), 16'h40);
    check("rst_dp", 16'(dp), 16'd1);
    rst = 1'b0;

    // Basic conversion.
    convert("c27", 9'd27, 12'h027, 12'h000, dpl);
    check("c27_dp_never", 16'(dpl), 16'd0);

    // Maximum value with carry, full scan.
    convert("c510", 9'd510, 12'h510, 12'h027, dpl);
    scan_check("scan510", 7'h40, 7'h79, 7'h12, 1'b0);

    // Busy ignore: second request three cycles later is dropped.
    pulses = 0; hold_err = 0;
    @(negedge clk); sum = 9'd10; cargar = 1'b1;
    @(posedge clk);
    @(negedge clk); cargar = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 2) begin sum = 9'd200; cargar = 1'b1; end
      if (k == 3) cargar = 1'b0;
      if (valido) pulses++;
      if (k < 9 && bcd !== 12'h510) hold_err++;
    end
    check("busy_pulses", 16'(pulses), 16'd1);
    check("busy_hold", 16'(hold_err), 16'd0);
    check("busy_bcd", 16'(bcd), 16'h010);

    // Leading-zero blanking for 10, then 0.
    scan_check("scan10", 7'h40, 7'h79, 7'h7F, 1'b1);
    convert("c0", 9'd0, 12'h000, 12'h010, dpl);
    scan_check("scan0", 7'h40, 7'h7F, 7'h7F, 1'b1);

    // Reset mid-conversion, asserted between edges.
    @(negedge clk); sum = 9'd255; cargar = 1'b1;
    @(posedge clk);
    @(negedge clk); cargar = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("amid_listo", 16'(listo), 16'd1);
    check("amid_bcd", 16'(bcd), 16'h000);
    check("amid_an", 16'(an), 16'(3'b110));
    check("amid_seg", 16'(seg), 16'h40);
    check("amid_valido", 16'(valido), 16'd0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (valido) pulses++;
    end
    check("amid_no_valido", 16'(pulses), 16'd0);
    check("amid_bcd_after", 16'(bcd), 16'h000);

    // Back-to-back loads: accepts at N, N+11, N+22, N+33.
    np = 0; prev_k = -2;
    @(negedge clk); sum = 9'd19; cargar = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      if (k % 11 == 0) sum = ((k / 11) % 2 == 0) ? 9'd6 : 9'd19;
      if (k == 43) cargar = 1'b0;
      if (valido) begin
        check("b2b_phase", 16'(k % 11), 16'd9);
        if (np > 0) check("b2b_gap", 16'(k - prev_k), 16'd11);
        check("b2b_bcd", 16'(bcd), (np % 2 == 0) ? 16'h019 : 16'h006);
        prev_k = k;
        np++;
      end
    end
    check("b2b_pulses", 16'(np), 16'd4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
